pipeline_ctrl: RTL and testbench

//  Central stall/flush controller for the 5-stage pipeline. Merges stall requests from IF (icache

---
 rtl/pipeline_ctrl_pkg.sv | 28 ++
 rtl/pipeline_ctrl_watchdog.sv | 48 ++++
 rtl/pipeline_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stage indices,
// controller states and the canonical StallBus patterns.
package pipeline_ctrl_pkg;

  localparam int STALL_BUS_W = 6;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  typedef logic [STALL_BUS_W-1:0] stall_bus_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } ctrl_state_e;

  // Each pattern freezes PC up to and including the requesting stage.
  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_IF   = 6'b000011;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_MEM  = 6'b011111;

endpackage

// File: rtl/pipeline_ctrl_watchdog.sv
// Counts consecutive stalled ready cycles and raises a sticky hang flag once
// the count reaches TIMEOUT; the counter saturates there.
module pipeline_ctrl_watchdog
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  input  logic stalled_in,
  output logic hang_out
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count_q, count_d;
  logic          hang_q, hang_d;

  always_comb begin
    count_d = count_q;
    hang_d  = hang_q;
    if (rdy_in) begin
      if (!stalled_in) begin
        count_d = '0;
      end else if (count_q != LIMIT) begin
        count_d = count_q + CW'(1);
      end
      if (count_d == LIMIT) begin
        hang_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_q <= '0;
      hang_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      hang_q  <= hang_d;
    end
  end

  assign hang_out = hang_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: merges IF/ID/MEM stall requests and EX
// redirects into the StallBus, replays redirects deferred by a MEM stall.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int STALL_W = 6,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               if_stall_req,
  input  logic               id_stall_req,
  input  logic               mem_req_start,
  input  logic               mem_req_done,
  input  logic               jump_enable,
  input  logic [31:0]        jump_target,
  output logic [STALL_W-1:0] stall_out,
  output logic               flush_out,
  output logic [31:0]        pc_redirect_out,
  output logic               hang_out,
  output logic [CNT_W-1:0]   stall_cycles_out
);

  ctrl_state_e      state_q, state_d;
  logic             jump_pending_q, jump_pending_d;
  logic [31:0]      jump_target_q, jump_target_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  stall_bus_t       stall_bus;
  logic             flush;
  logic [31:0]      redirect;
  logic             mem_begin;
  logic             run_jump;
  logic             wd_hang;

  // A zero-wait access (start and done together) never leaves RUN.
  assign mem_begin = mem_req_start && !mem_req_done;
  assign run_jump  = (state_q == ST_RUN) && jump_enable && !mem_begin;

  always_comb begin
    state_d        = state_q;
    jump_pending_d = jump_pending_q;
    jump_target_d  = jump_target_q;
    if (rdy_in) begin
      unique case (state_q)
        ST_RUN: begin
          if (mem_begin) begin
            state_d = ST_MEM_WAIT;
            if (jump_enable) begin
              jump_pending_d = 1'b1;
              jump_target_d  = jump_target;
            end
          end
        end
        ST_MEM_WAIT: begin
          if (jump_enable) begin
            jump_pending_d = 1'b1;
            jump_target_d  = jump_target;
          end
          if (mem_req_done) begin
            state_d = (jump_pending_q || jump_enable) ? ST_FLUSH : ST_RUN;
          end
        end
        ST_FLUSH: begin
          jump_pending_d = 1'b0;
          state_d        = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Priority: MEM stall, then a flush (replayed or live), then ID, then IF.
  always_comb begin
    stall_bus = STALL_NONE;
    flush     = 1'b0;
    redirect  = '0;
    if (state_q == ST_MEM_WAIT) begin
      stall_bus = STALL_MEM;
    end else if (state_q == ST_FLUSH) begin
      flush    = 1'b1;
      redirect = jump_target_q;
    end else if (run_jump) begin
      flush    = 1'b1;
      redirect = jump_target;
    end else if (id_stall_req) begin
      stall_bus = STALL_ID;
    end else if (if_stall_req) begin
      stall_bus = STALL_IF;
    end
  end

  always_comb begin
    cycles_d = cycles_q;
    if (rdy_in && stall_bus[STG_PC]) begin
      cycles_d = cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= ST_RUN;
      jump_pending_q <= 1'b0;
      jump_target_q  <= '0;
      cycles_q       <= '0;
    end else begin
      state_q        <= state_d;
      jump_pending_q <= jump_pending_d;
      jump_target_q  <= jump_target_d;
      cycles_q       <= cycles_d;
    end
  end

  pipeline_ctrl_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .stalled_in (stall_bus != STALL_NONE),
    .hang_out   (wd_hang)
  );

  // Combinational outputs are forced quiet while reset is held.
  assign stall_out        = rst_in ? '0 : STALL_W'(stall_bus);
  assign flush_out        = rst_in ? 1'b0 : flush;
  assign pc_redirect_out  = rst_in ? '0 : redirect;
  assign hang_out         = wd_hang;
  assign stall_cycles_out = cycles_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: each scenario queues expected outputs as
// it drives a cycle and pops them against the DUT before the next edge.
module tb_pipeline_ctrl;

  localparam int TO = 8;
  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;
  localparam logic [5:0] S0   = 6'b000000;
  localparam logic [5:0] SIF  = 6'b000011;
  localparam logic [5:0] SID  = 6'b000111;
  localparam logic [5:0] SMEM = 6'b011111;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, if_stall_req, id_stall_req;
  logic        mem_req_start, mem_req_done, jump_enable;
  logic [31:0] jump_target;
  logic [5:0]  stall_out;
  logic        flush_out, hang_out;
  logic [31:0] pc_redirect_out, stall_cycles_out;

  typedef struct {
    logic rst, rdy, ifr, idr, st, dn, je;
    logic [31:0] jt;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] redir;
  } vec_t;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] redir;
    logic        hang;
    logic [31:0] cycles;
  } exp_t;

  exp_t        sb[$];
  int          nVec = 0;
  int          nFail = 0;
  logic [31:0] mCycles = '0;
  int          mWdCnt = 0;
  logic        mHang = 1'b0;

  pipeline_ctrl #(.STALL_W(6), .TIMEOUT(TO), .CNT_W(32)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .if_stall_req     (if_stall_req),
    .id_stall_req     (id_stall_req),
    .mem_req_start    (mem_req_start),
    .mem_req_done     (mem_req_done),
    .jump_enable      (jump_enable),
    .jump_target      (jump_target),
    .stall_out        (stall_out),
    .flush_out        (flush_out),
    .pc_redirect_out  (pc_redirect_out),
    .hang_out         (hang_out),
    .stall_cycles_out (stall_cycles_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic vec_t mk(input logic rst, rdy, ifr, idr, st, dn, je,
                              input logic [31:0] jt, input logic [5:0] stall,
                              input logic flush, input logic [31:0] redir);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.ifr = ifr; v.idr = idr;
    v.st = st; v.dn = dn; v.je = je; v.jt = jt;
    v.stall = stall; v.flush = flush; v.redir = redir;
    return v;
  endfunction

  // Drive one cycle at the falling edge, queue its expectation, then advance
  // the counter/watchdog model by what the coming rising edge should register.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk_in);
    rst_in = v.rst; rdy_in = v.rdy; if_stall_req = v.ifr; id_stall_req = v.idr;
    mem_req_start = v.st; mem_req_done = v.dn; jump_enable = v.je; jump_target = v.jt;
    if (v.rst) begin
      mCycles = '0; mWdCnt = 0; mHang = 1'b0;
    end
    e.stall = v.stall; e.flush = v.flush; e.redir = v.redir;
    e.hang = mHang; e.cycles = mCycles;
    sb.push_back(e);
    if (!v.rst && v.rdy) begin
      if (v.stall[0]) mCycles = mCycles + 32'd1;
      if (v.stall != S0) begin
        if (mWdCnt < TO) mWdCnt++;
        if (mWdCnt == TO) mHang = 1'b1;
      end else begin
        mWdCnt = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    vec_t t[$];
    exp_t e;
    t.push_back(mk(Y, Y, N, Y, N, N, Y, 32'hDEAD, S0, N, 32'h0));
    t.push_back(mk(Y, Y, Y, N, Y, N, N, 32'h0,    S0, N, 32'h0));
    t.push_back(mk(N, Y, N, N, N, N, N, 32'h0,    S0, N, 32'h0));
    foreach (t[i]) begin
      applyStimulus(t[i]);
      e = sb.pop_front();
      nVec++;
      if ({stall_out, flush_out, pc_redirect_out, hang_out, stall_cycles_out} !==
          {e.stall, e.flush, e.redir, e.hang, e.cycles}) begin
        nFail++;
        $display("[TB] FAIL reset[%0d]: got stall=%b flush=%b pc=%h hang=%b cyc=%0d, want stall=%b flush=%b pc=%h hang=%b cyc=%0d",
                 i, stall_out, flush_out, pc_redirect_out, hang_out, stall_cycles_out,
                 e.stall, e.flush, e.redir, e.hang, e.cycles);
      end
    end
  endtask

  task automatic test_id_stall();
    vec_t t[$];
    exp_t e;
    t.push_back(mk(N, Y, N, Y, N, N, N, 32'h0, SID, N, 32'h0));
    t.push_back(mk(N, Y, N, N, N, N, N, 32'h0, S0,  N, 32'h0));
    t.push_back(mk(N, Y, Y, N, N, N, N, 32'h0, SIF, N, 32'h0));
    t.push_back(mk(N, Y, Y, Y, N, N, N, 32'h0, SID, N, 32'h0));
    t.push_back(mk(N, Y, N, N, N, N, N, 32'h0, S0,  N, 32'h0));
    foreach (t[i]) begin
      applyStimulus(t[i]);
      e = sb.pop_front();
      nVec++;
      if ({stall_out, flush_out, pc_redirect_out, hang_out, stall_cycles_out} !==
          {e.stall, e.flush, e.redir, e.hang, e.cycles}) begin
        nFail++;
        $display("[TB] FAIL id_stall[%0d]: got stall=%b flush=%b pc=%h hang=%b cyc=%0d, want stall=%b flush=%b pc=%h hang=%b cyc=%0d",
                 i, stall_out, flush_out, pc_redirect_out, hang_out, stall_cycles_out,
                 e.stall, e.flush, e.redir, e.hang, e.cycles);
      end
    end
  endtask

  task automatic test_mem_wait();
    vec_t t[$];
    exp_t e;
    t.push_back(mk(N, Y, N, N, Y, N, N, 32'h0, S0, N, 32'h0));
    for (int k = 1; k <= 4; k++) begin
      t.push_back(mk(N, Y, N, (k == 2), N, (k == 4), N, 32'h0, SMEM, N, 32'h0));
    end
    t.push_back(mk(N, Y, N, N, N, N, N, 32'h0, S0, N, 32'h0));
    t.push_back(mk(N, Y, N, N, N, N, N, 32'h0, S0, N, 32'h0));
    foreach (t[i]) begin
      applyStimulus(t[i]);
      e = sb.pop_front();
      nVec++;
      if ({stall_out, flush_out, pc_redirect_out, hang_out, stall_cycles_out} !==
          {e.stall, e.flush, e.redir, e.hang, e.cycles}) begin
        nFail++;
        $display("[TB] FAIL mem_wait[%0d]: got stall=%b flush=%b pc=%h hang=%b cyc=%0d, want stall=%b flush=%b pc=%h hang=%b cyc=%0d",
                 i, stall_out, flush_out, pc_redirect_out, hang_out, stall_cycles_out,
                 e.stall, e.flush, e.redir, e.hang, e.cycles);
      end
    end
  endtask

  task automatic test_ready_hold();
    vec_t t[$];
    exp_t e;
    t.push_back(mk(N, Y, N, N, Y, N, N, 32'h0, S0,   N, 32'h0));
    t.push_back(mk(N, Y, N, N, N, N, N, 32'h0, SMEM, N, 32'h0));
    t.push_back(mk(N, N, N, N, N, Y, N, 32'h0, SMEM, N, 32'h0));
    t.push_back(mk(N, N, N, Y, N, N, N, 32'h0, SMEM, N, 32'h0));
    t.push_back(mk(N, Y, N, N, N, Y, N, 32'h0, SMEM, N, 32'h0));
    t.push_back(mk(N, Y, N, N, N, N, N, 32'h0, S0,   N, 32'h0));
    foreach (t[i]) begin
      applyStimulus(t[i]);
      e = sb.pop_front();
      nVec++;
      if ({stall_out, flush_out, pc_redirect_out, hang_out, stall_cycles_out} !==
          {e.stall, e.flush, e.redir, e.hang, e.cycles}) begin
        nFail++;
        $display("[TB] FAIL ready_hold[%0d]: got stall=%b flush=%b pc=%h hang=%b cyc=%0d, want stall=%b flush=%b pc=%h hang=%b cyc=%0d",
                 i, stall_out, flush_out, pc_redirect_out, hang_out, stall_cycles_out,
                 e.stall, e.flush, e.redir, e.hang, e.cycles);
      end
    end
  endtask

  task automatic test_jump_replay();
    vec_t t[$];
    exp_t e;
    t.push_back(mk(N, Y, N, N, Y, N, N, 32'h0,    S0,   N, 32'h0));
    t.push_back(mk(N, Y, N, N, N, N, Y, 32'h2000, SMEM, N, 32'h0));
    t.push_back(mk(N, Y, N, N, N, N, Y, 32'h1000, SMEM, N, 32'h0));
    t.push_back(mk(N, Y, N, N, N, Y, N, 32'h0,    SMEM, N, 32'h0));
    t.push_back(mk(N, Y, Y, Y, N, N, N, 32'h0,    S0,   Y, 32'h1000));
    t.push_back(mk(N, Y, N, Y, N, N, N, 32'h0,    SID,  N, 32'h0));
    t.push_back(mk(N, Y, N, N, N, N, N, 32'h0,    S0,   N, 32'h0));
    foreach (t[i]) begin
      applyStimulus(t[i]);
      e = sb.pop_front();
      nVec++;
      if ({stall_out, flush_out, pc_redirect_out, hang_out, stall_cycles_out} !==
          {e.stall, e.flush, e.redir, e.hang, e.cycles}) begin
        nFail++;
        $display("[TB] FAIL jump_replay[%0d]: got stall=%b flush=%b pc=%h hang=%b cyc=%0d, want stall=%b flush=%b pc=%h hang=%b cyc=%0d",
                 i, stall_out, flush_out, pc_redirect_out, hang_out, stall_cycles_out,
                 e.stall, e.flush, e.redir, e.hang, e.cycles);
      end
    end
  endtask

  task automatic test_jump_with_if();
    vec_t t[$];
    exp_t e;
    t.push_back(mk(N, Y, Y, N, N, N, Y, 32'h44, S0,  Y, 32'h44));
    t.push_back(mk(N, Y, Y, N, N, N, N, 32'h0,  SIF, N, 32'h0));
    t.push_back(mk(N, Y, N, Y, N, N, Y, 32'h88, S0,  Y, 32'h88));
    t.push_back(mk(N, Y, N, N, N, N, N, 32'h0,  S0,  N, 32'h0));
    foreach (t[i]) begin
      applyStimulus(t[i]);
      e = sb.pop_front();
      nVec++;
      if ({stall_out, flush_out, pc_redirect_out, hang_out, stall_cycles_out} !==
          {e.stall, e.flush, e.redir, e.hang, e.cycles}) begin
        nFail++;
        $display("[TB] FAIL jump_with_if[%0d]: got stall=%b flush=%b pc=%h hang=%b cyc=%0d, want stall=%b flush=%b pc=%h hang=%b cyc=%0d",
                 i, stall_out, flush_out, pc_redirect_out, hang_out, stall_cycles_out,
                 e.stall, e.flush, e.redir, e.hang, e.cycles);
      end
    end
  endtask

  task automatic test_zero_wait();
    vec_t t[$];
    exp_t e;
    t.push_back(mk(N, Y, N, N, Y, Y, N, 32'h0, S0,  N, 32'h0));
    t.push_back(mk(N, Y, N, N, N, N, N, 32'h0, S0,  N, 32'h0));
    t.push_back(mk(N, Y, N, N, N, Y, N, 32'h0, S0,  N, 32'h0));
    t.push_back(mk(N, Y, N, Y, N, N, N, 32'h0, SID, N, 32'h0));
    t.push_back(mk(N, Y, N, N, N, N, N, 32'h0, S0,  N, 32'h0));
    foreach (t[i]) begin
      applyStimulus(t[i]);
      e = sb.pop_front();
      nVec++;
      if ({stall_out, flush_out, pc_redirect_out, hang_out, stall_cycles_out} !==
          {e.stall, e.flush, e.redir, e.hang, e.cycles}) begin
        nFail++;
        $display("[TB] FAIL zero_wait[%0d]: got stall=%b flush=%b pc=%h hang=%b cyc=%0d, want stall=%b flush=%b pc=%h hang=%b cyc=%0d",
                 i, stall_out, flush_out, pc_redirect_out, hang_out, stall_cycles_out,
                 e.stall, e.flush, e.redir, e.hang, e.cycles);
      end
    end
  endtask

  task automatic test_watchdog();
    vec_t t[$];
    exp_t e;
    t.push_back(mk(Y, Y, N, N, N, N, N, 32'h0, S0, N, 32'h0));
    t.push_back(mk(N, Y, N, N, N, N, N, 32'h0, S0, N, 32'h0));
    t.push_back(mk(N, Y, N, N, Y, N, N, 32'h0, S0, N, 32'h0));
    for (int k = 1; k <= 10; k++) begin
      t.push_back(mk(N, Y, N, N, N, (k == 10), N, 32'h0, SMEM, N, 32'h0));
    end
    t.push_back(mk(N, Y, N, N, N, N, N, 32'h0, S0, N, 32'h0));
    t.push_back(mk(N, Y, N, N, N, N, N, 32'h0, S0, N, 32'h0));
    foreach (t[i]) begin
      applyStimulus(t[i]);
      e = sb.pop_front();
      nVec++;
      if ({stall_out, flush_out, pc_redirect_out, hang_out, stall_cycles_out} !==
          {e.stall, e.flush, e.redir, e.hang, e.cycles}) begin
        nFail++;
        $display("[TB] FAIL watchdog[%0d]: got stall=%b flush=%b pc=%h hang=%b cyc=%0d, want stall=%b flush=%b pc=%h hang=%b cyc=%0d",
                 i, stall_out, flush_out, pc_redirect_out, hang_out, stall_cycles_out,
                 e.stall, e.flush, e.redir, e.hang, e.cycles);
      end
    end
  endtask

  task automatic test_reset_mid();
    vec_t t[$];
    exp_t e;
    t.push_back(mk(N, Y, N, N, Y, N, N, 32'h0,    S0,   N, 32'h0));
    t.push_back(mk(N, Y, N, N, N, N, Y, 32'h3000, SMEM, N, 32'h0));
    t.push_back(mk(Y, Y, N, Y, N, N, Y, 32'h4000, S0,   N, 32'h0));
    t.push_back(mk(N, Y, N, N, N, N, N, 32'h0,    S0,   N, 32'h0));
    t.push_back(mk(N, Y, N, N, N, Y, N, 32'h0,    S0,   N, 32'h0));
    t.push_back(mk(N, Y, N, Y, N, N, N, 32'h0,    SID,  N, 32'h0));
    t.push_back(mk(N, Y, N, N, N, N, N, 32'h0,    S0,   N, 32'h0));
    foreach (t[i]) begin
      applyStimulus(t[i]);
      e = sb.pop_front();
      nVec++;
      if ({stall_out, flush_out, pc_redirect_out, hang_out, stall_cycles_out} !==
          {e.stall, e.flush, e.redir, e.hang, e.cycles}) begin
        nFail++;
        $display("[TB] FAIL reset_mid[%0d]: got stall=%b flush=%b pc=%h hang=%b cyc=%0d, want stall=%b flush=%b pc=%h hang=%b cyc=%0d",
                 i, stall_out, flush_out, pc_redirect_out, hang_out, stall_cycles_out,
                 e.stall, e.flush, e.redir, e.hang, e.cycles);
      end
    end
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; if_stall_req = 1'b0; id_stall_req = 1'b0;
    mem_req_start = 1'b0; mem_req_done = 1'b0; jump_enable = 1'b0; jump_target = '0;
    test_reset();
    test_id_stall();
    test_mem_wait();
    test_ready_hold();
    test_jump_replay();
    test_jump_with_if();
    test_zero_wait();
    test_watchdog();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
